// File: rtl/cok_cevrimli_islemci.sv
// Multi-cycle RV32I subset core: GETIR -> YURUT -> (BELLEK) -> GERIYAZ, halting in DURDU
// on ECALL or on any decode/alignment/range error.
module cok_cevrimli_islemci #(
  parameter int unsigned YAZMAC_SAYISI = 8,
  parameter int unsigned VERI_DERINLIK = 128,
  parameter logic [31:0] BASLANGIC_PS  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] buyruk,
  input  logic        buyruk_gecerli,
  output logic [31:0] ps,
  output logic        ps_gecerli,
  output logic        durdu,
  output logic        hata,
  output logic [31:0] tamamlanan,
  input  logic [4:0]  gozlem_adres,
  output logic [31:0] gozlem_veri
);
  localparam int unsigned YW = (YAZMAC_SAYISI > 1) ? $clog2(YAZMAC_SAYISI) : 1;
  localparam int unsigned AW = (VERI_DERINLIK > 1) ? $clog2(VERI_DERINLIK) : 1;

  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpSystem = 7'b1110011;

  typedef enum logic [2:0] {StGetir, StYurut, StBellek, StGeriyaz, StDurdu} durum_e;
  durum_e durum_q, durum_d;

  logic [31:0] ps_q, buyruk_q, sonuc_q, sonuc_d, hedef_q, hedef_d, tamamlanan_q;
  logic [AW-1:0] adres_q;
  logic        yaz_q, yaz_d, hata_q, calisiyor_q;
  logic [31:0] rf_q [YAZMAC_SAYISI];
  logic [31:0] veri_bellek [VERI_DERINLIK];

  logic [6:0]  opkod, f7;
  logic [2:0]  f3;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u, rs1_v, rs2_v, ea;
  logic        destek, rs1_kul, rs2_kul, rd_kul, bellek, atlama, yurut_hata, ecall;

  assign opkod = buyruk_q[6:0];
  assign rd    = buyruk_q[11:7];
  assign f3    = buyruk_q[14:12];
  assign rs1   = buyruk_q[19:15];
  assign rs2   = buyruk_q[24:20];
  assign f7    = buyruk_q[31:25];
  assign imm_i = {{20{buyruk_q[31]}}, buyruk_q[31:20]};
  assign imm_s = {{20{buyruk_q[31]}}, buyruk_q[31:25], buyruk_q[11:7]};
  assign imm_b = {{19{buyruk_q[31]}}, buyruk_q[31], buyruk_q[7], buyruk_q[30:25],
                  buyruk_q[11:8], 1'b0};
  assign imm_j = {{11{buyruk_q[31]}}, buyruk_q[31], buyruk_q[19:12], buyruk_q[20],
                  buyruk_q[30:21], 1'b0};
  assign imm_u = {buyruk_q[31:12], 12'b0};
  assign ecall = (buyruk_q == 32'h0000_0073);

  // Indices at or beyond the file size read as zero (and are flagged as errors when used).
  assign rs1_v = (rs1 != 5'd0 && {27'b0, rs1} < YAZMAC_SAYISI) ? rf_q[rs1[YW-1:0]] : '0;
  assign rs2_v = (rs2 != 5'd0 && {27'b0, rs2} < YAZMAC_SAYISI) ? rf_q[rs2[YW-1:0]] : '0;
  assign gozlem_veri = (gozlem_adres != 5'd0 && {27'b0, gozlem_adres} < YAZMAC_SAYISI) ?
                       rf_q[gozlem_adres[YW-1:0]] : '0;
  assign ea = rs1_v + ((opkod == OpStore) ? imm_s : imm_i);

  always_comb begin
    destek  = 1'b0;
    rs1_kul = 1'b0;
    rs2_kul = 1'b0;
    rd_kul  = 1'b0;
    bellek  = 1'b0;
    atlama  = 1'b0;
    sonuc_d = '0;
    hedef_d = ps_q + 32'd4;
    case (opkod)
      OpImm: if (f3 == 3'b000) begin
        destek = 1'b1; rs1_kul = 1'b1; rd_kul = 1'b1;
        sonuc_d = rs1_v + imm_i;
      end
      OpReg: begin
        destek = 1'b1; rs1_kul = 1'b1; rs2_kul = 1'b1; rd_kul = 1'b1;
        case ({f7, f3})
          {7'h00, 3'b000}: sonuc_d = rs1_v + rs2_v;
          {7'h20, 3'b000}: sonuc_d = rs1_v - rs2_v;
          {7'h00, 3'b110}: sonuc_d = rs1_v | rs2_v;
          {7'h00, 3'b111}: sonuc_d = rs1_v & rs2_v;
          {7'h00, 3'b100}: sonuc_d = rs1_v ^ rs2_v;
          default:         destek  = 1'b0;
        endcase
      end
      OpBranch: begin
        rs1_kul = 1'b1; rs2_kul = 1'b1; destek = 1'b1;
        case (f3)
          3'b000:  atlama = (rs1_v == rs2_v);
          3'b001:  atlama = (rs1_v != rs2_v);
          3'b100:  atlama = ($signed(rs1_v) < $signed(rs2_v));
          default: destek = 1'b0;
        endcase
        if (atlama) hedef_d = ps_q + imm_b;
      end
      OpJal: begin
        destek = 1'b1; rd_kul = 1'b1; atlama = 1'b1;
        sonuc_d = ps_q + 32'd4;
        hedef_d = ps_q + imm_j;
      end
      OpJalr: if (f3 == 3'b000) begin
        destek = 1'b1; rs1_kul = 1'b1; rd_kul = 1'b1; atlama = 1'b1;
        sonuc_d = ps_q + 32'd4;
        hedef_d = (rs1_v + imm_i) & ~32'd1;
      end
      OpLui:   begin destek = 1'b1; rd_kul = 1'b1; sonuc_d = imm_u; end
      OpAuipc: begin destek = 1'b1; rd_kul = 1'b1; sonuc_d = ps_q + imm_u; end
      OpLoad: if (f3 == 3'b010) begin
        destek = 1'b1; rs1_kul = 1'b1; rd_kul = 1'b1; bellek = 1'b1;
      end
      OpStore: if (f3 == 3'b010) begin
        destek = 1'b1; rs1_kul = 1'b1; rs2_kul = 1'b1; bellek = 1'b1;
      end
      OpSystem: if (ecall) begin destek = 1'b1; hedef_d = ps_q; end
      default: ;
    endcase
    yaz_d = rd_kul && (rd != 5'd0);
  end

  assign yurut_hata = !destek
      || (rs1_kul && {27'b0, rs1} >= YAZMAC_SAYISI)
      || (rs2_kul && {27'b0, rs2} >= YAZMAC_SAYISI)
      || (rd_kul  && {27'b0, rd}  >= YAZMAC_SAYISI)
      || (bellek && (ea[1:0] != 2'b00 || {2'b00, ea[31:2]} >= VERI_DERINLIK))
      || (atlama && hedef_d[1:0] != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) durum_q <= StGetir;
    else     durum_q <= durum_d;
  end

  always_comb begin
    durum_d = durum_q;
    unique case (durum_q)
      StGetir:   if (ps_gecerli && buyruk_gecerli) durum_d = StYurut;
      StYurut:   durum_d = yurut_hata ? StDurdu : (bellek ? StBellek : StGeriyaz);
      StBellek:  durum_d = StGeriyaz;
      StGeriyaz: durum_d = ecall ? StDurdu : StGetir;
      StDurdu:   durum_d = StDurdu;
      default:   durum_d = StGetir;
    endcase
  end

  always_comb begin
    ps_gecerli = (durum_q == StGetir) && calisiyor_q;
    durdu      = (durum_q == StDurdu);
    hata       = hata_q;
    ps         = ps_q;
    tamamlanan = tamamlanan_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps_q         <= BASLANGIC_PS;
      buyruk_q     <= '0;
      sonuc_q      <= '0;
      hedef_q      <= '0;
      adres_q      <= '0;
      yaz_q        <= 1'b0;
      hata_q       <= 1'b0;
      calisiyor_q  <= 1'b0;
      tamamlanan_q <= '0;
      for (int i = 0; i < int'(YAZMAC_SAYISI); i++) rf_q[i] <= '0;
    end else begin
      calisiyor_q <= 1'b1;
      unique case (durum_q)
        StGetir: if (ps_gecerli && buyruk_gecerli) buyruk_q <= buyruk;
        StYurut: begin
          sonuc_q <= sonuc_d;
          hedef_q <= hedef_d;
          adres_q <= ea[AW+1:2];
          yaz_q   <= yaz_d;
          if (yurut_hata) hata_q <= 1'b1;
        end
        StBellek: if (opkod == OpLoad) sonuc_q <= veri_bellek[adres_q];
        StGeriyaz: begin
          ps_q         <= hedef_q;
          tamamlanan_q <= tamamlanan_q + 32'd1;
          if (yaz_q) rf_q[rd[YW-1:0]] <= sonuc_q;
        end
        default: ;
      endcase
    end
  end

  // Data memory is deliberately outside the reset domain; async reset leaves state in GETIR,
  // so a store interrupted in BELLEK never writes.
  always_ff @(posedge clk) begin
    if (durum_q == StBellek && opkod == OpStore) veri_bellek[adres_q] <= rs2_v;
  end

endmodule

// File: doc/cok_cevrimli_islemci.md
COK_CEVRIMLI_ISLEMCI -- requirements
Module: cok_cevrimli_islemci

Interface
REQ-001 SHALL have parameter YAZMAC_SAYISI, default 8: register-file entries; power of two, 2..32.
REQ-002 SHALL have parameter VERI_DERINLIK, default 128: data-memory depth in 32-bit words; power of two.
REQ-003 SHALL have parameter BASLANGIC_PS, default 32'h0000_0000: program counter after reset.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port buyruk  input  32  instruction for address ps.
REQ-007 SHALL have port buyruk_gecerli  input  1  buyruk valid this cycle.
REQ-008 SHALL have port ps  output  32  fetch address, word-aligned.
REQ-009 SHALL have port ps_gecerli  output  1  fetch request; high only in state GETIR.
REQ-010 SHALL have port durdu  output  1  core halted.
REQ-011 SHALL have port hata  output  1  halt was caused by an error.
REQ-012 SHALL have port tamamlanan  output  32  retired-instruction count.
REQ-013 SHALL have port gozlem_adres  input  5  debug register index.
REQ-014 SHALL have port gozlem_veri  output  32  combinational read of that register; 0 if index is 0 or >= YAZMAC_SAYISI.

Function
REQ-015 SHALL implement the FSM GETIR -> YURUT -> (BELLEK for LW/SW only) -> GERIYAZ -> GETIR, plus terminal state DURDU.
REQ-016 SHALL latch buyruk in GETIR only on a rising edge with ps_gecerli=1 and buyruk_gecerli=1; otherwise stay in GETIR with ps unchanged.
REQ-017 SHALL take 3 cycles from handshake edge to next GETIR for non-memory instructions, and 4 for LW/SW.
REQ-018 SHALL execute ADDI, ADD, SUB, OR, AND, XOR, BEQ, BNE, BLT, JAL, JALR, LUI, AUIPC, LW, SW and ECALL with standard RV32I encodings and sign-extended immediates.
REQ-019 SHALL compute BLT as a signed compare, and all arithmetic modulo 2^32.
REQ-020 SHALL set branch/JAL targets to ps + imm, JALR target to (rs1 + imm) with bit0 cleared, and AUIPC to ps + (imm20 << 12).
REQ-021 SHALL write ps+4 to rd for JAL/JALR, using the ps of the jumping instruction.
REQ-022 SHALL update ps and the register file only at the end of GERIYAZ; register 0 always reads 0 and ignores writes.
REQ-023 SHALL address data memory with word index = (rs1 + imm) >> 2.
REQ-024 SHALL write memory in BELLEK for SW, and capture read data in BELLEK for LW.
REQ-025 SHALL increment tamamlanan by 1 at the end of each GERIYAZ, wrapping from 32'hFFFF_FFFF to 0.
REQ-026 SHALL treat these as errors: unsupported opcode/funct; any rs1/rs2/rd index >= YAZMAC_SAYISI; LW/SW address not 4-byte aligned or word index >= VERI_DERINLIK; a taken jump/branch target not 4-byte aligned.
REQ-027 SHALL, on an error, enter DURDU with hata=1, leave registers/memory/ps unchanged, and not increment tamamlanan.
REQ-028 SHALL, on ECALL (32'h0000_0073), increment tamamlanan, enter DURDU with hata=0, and keep ps at the ECALL address.
REQ-029 SHALL, in DURDU, hold durdu=1 and ps_gecerli=0 and ignore buyruk until reset.

Reset
REQ-030 SHALL, while rst=1, immediately force: state GETIR, ps=BASLANGIC_PS, ps_gecerli=0, durdu=0, hata=0, tamamlanan=0, all registers 0.
REQ-031 SHALL raise ps_gecerli on the first rising edge after rst falls.
REQ-032 SHALL leave data memory contents unchanged by reset.
REQ-033 SHALL abort any in-flight instruction on reset, with no register write, no memory write and no count increment.

Verification
REQ-034 SHALL cover ADDI: reset, then 32'h0050_0093 (ADDI x1,x0,5) -> after 3 cycles gozlem x1=5, ps=4, tamamlanan=1.
REQ-035 SHALL cover memory: ADDI x2,x0,-1; SW x2,8(x0); LW x3,8(x0) -> x3=32'hFFFF_FFFF, the LW taking 4 cycles.
REQ-036 SHALL cover branches: x1=-1, x2=1, BLT x1,x2,+8 at ps=0x0C -> ps=0x14; then BEQ x1,x2,+8 -> ps+4.
REQ-037 SHALL cover JAL: JAL x1,+16 at ps=0x10 -> x1=0x14, ps=0x20; then JALR to an unaligned target -> durdu=1, hata=1.
REQ-038 SHALL cover fetch stall and halt: buyruk_gecerli low for 5 cycles -> ps and tamamlanan stable; then ECALL -> durdu=1, hata=0, ps_gecerli=0.
REQ-039 SHALL cover reset mid-operation: assert rst in BELLEK of an SW -> outputs reach reset values before the next edge, and the target word is unchanged.
